// File: rtl/arithmetic_unit.sv
// RV32I OP-class integer ALU: decodes funct3/funct7 and registers a 32-bit result.
// Illegal or partially-valid requests produce result_valid=0 with a zeroed result.
module arithmetic_unit (
    input  logic          clk,
    input  logic          rst,
    input  logic [31:0]   lhs,
    input  logic          lhs_valid,
    input  logic [31:0]   rhs,
    input  logic          rhs_valid,
    input  logic [14:12]  operation,
    input  logic          operation_valid,
    input  logic [31:25]  metadata,
    input  logic          metadata_valid,
    output logic [31:0]   result,
    output logic          result_valid
);

    typedef enum logic [2:0] {
        F3_ADD  = 3'd0,
        F3_SLL  = 3'd1,
        F3_SLT  = 3'd2,
        F3_SLTU = 3'd3,
        F3_XOR  = 3'd4,
        F3_SR   = 3'd5,
        F3_OR   = 3'd6,
        F3_AND  = 3'd7
    } funct3_e;

    typedef enum logic [6:0] {
        F7_BASE = 7'h00,
        F7_ALT  = 7'h20
    } funct7_e;

    funct3_e     f3;
    logic        md_base;
    logic        md_alt;
    logic        legal;
    logic        accept;
    logic        shift_big;
    logic [4:0]  shamt;
    logic [31:0] alu_out;

    assign f3      = funct3_e'(operation);
    assign md_base = (metadata == F7_BASE);
    assign md_alt  = (metadata == F7_ALT);

    // The full 32-bit rhs is the shift amount, so any bit above [4] saturates the shift.
    assign shift_big = |rhs[31:5];
    assign shamt     = rhs[4:0];

    always_comb begin
        legal = md_base || (md_alt && (f3 == F3_ADD || f3 == F3_SR));
    end

    assign accept = lhs_valid && rhs_valid && operation_valid && metadata_valid && legal;

    always_comb begin
        alu_out = '0;
        unique case (f3)
            F3_ADD:  alu_out = md_alt ? (lhs - rhs) : (lhs + rhs);
            F3_SLL:  alu_out = shift_big ? '0 : (lhs << shamt);
            F3_SLT:  alu_out = {31'd0, ($signed(lhs) < $signed(rhs))};
            F3_SLTU: alu_out = {31'd0, (lhs < rhs)};
            F3_XOR:  alu_out = lhs ^ rhs;
            F3_SR: begin
                if (md_alt)
                    alu_out = shift_big ? {32{lhs[31]}} : 32'($signed(lhs) >>> shamt);
                else
                    alu_out = shift_big ? '0 : (lhs >> shamt);
            end
            F3_OR:   alu_out = lhs | rhs;
            F3_AND:  alu_out = lhs & rhs;
            default: alu_out = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            result       <= '0;
            result_valid <= 1'b0;
        end else begin
            result       <= accept ? alu_out : '0;
            result_valid <= accept;
        end
    end

endmodule

// File: tb/tb_arithmetic_unit.sv
// Directed-vector bench for arithmetic_unit: the driver queues expected results,
// a monitor pops and compares one cycle after each issued request.
module tb_arithmetic_unit;

    logic          clk;
    logic          rst;
    logic [31:0]   lhs;
    logic          lhs_valid;
    logic [31:0]   rhs;
    logic          rhs_valid;
    logic [14:12]  operation;
    logic          operation_valid;
    logic [31:25]  metadata;
    logic          metadata_valid;
    logic [31:0]   result;
    logic          result_valid;

    typedef struct {
        string       name;
        logic        v;
        logic [31:0] r;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   fails  = 0;

    arithmetic_unit dut (
        .clk             (clk),
        .rst             (rst),
        .lhs             (lhs),
        .lhs_valid       (lhs_valid),
        .rhs             (rhs),
        .rhs_valid       (rhs_valid),
        .operation       (operation),
        .operation_valid (operation_valid),
        .metadata        (metadata),
        .metadata_valid  (metadata_valid),
        .result          (result),
        .result_valid    (result_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: every issued request is captured at the next rising edge.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (rst && exp_q.size() != 0) begin
            e = exp_q.pop_front();
            checks++;
            if (result_valid !== e.v || result !== e.r) begin
                fails++;
                $display("FAIL %s: got valid=%0b result=%h, expected valid=%0b result=%h",
                         e.name, result_valid, result, e.v, e.r);
            end
        end
    end

    task automatic check_now(input string name, input logic ev, input logic [31:0] er);
        checks++;
        if (result_valid !== ev || result !== er) begin
            fails++;
            $display("FAIL %s: got valid=%0b result=%h, expected valid=%0b result=%h",
                     name, result_valid, result, ev, er);
        end
    endtask

    task automatic set_inputs(input logic lv, input logic rv, input logic ov, input logic mv,
                              input logic [2:0] f3, input logic [6:0] f7,
                              input logic [31:0] a, input logic [31:0] b);
        lhs_valid = lv; rhs_valid = rv; operation_valid = ov; metadata_valid = mv;
        operation = f3; metadata = f7; lhs = a; rhs = b;
    endtask

    // Called at a falling edge; holds the request for one full cycle.
    task automatic issue(input string name, input logic lv, input logic rv, input logic ov,
                         input logic mv, input logic [2:0] f3, input logic [6:0] f7,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic ev, input logic [31:0] er);
        exp_t e;
        set_inputs(lv, rv, ov, mv, f3, f7, a, b);
        e.name = name; e.v = ev; e.r = er;
        exp_q.push_back(e);
        @(negedge clk);
    endtask

    task automatic op_ok(input string name, input logic [2:0] f3, input logic [6:0] f7,
                         input logic [31:0] a, input logic [31:0] b, input logic [31:0] er);
        issue(name, 1'b1, 1'b1, 1'b1, 1'b1, f3, f7, a, b, 1'b1, er);
    endtask

    // Rejected requests carry operands that would give a nonzero sum if wrongly accepted.
    task automatic rej(input string name, input logic lv, input logic rv, input logic ov,
                       input logic mv, input logic [2:0] f3, input logic [6:0] f7);
        issue(name, lv, rv, ov, mv, f3, f7, 32'h0000_0005, 32'h0000_0007, 1'b0, 32'h0);
    endtask

    initial begin
        rst = 1'b0;
        set_inputs(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 7'h00, 32'h0, 32'h0);
        #1;
        check_now("reset_state", 1'b0, 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;

        rej("illegal_md01",     1, 1, 1, 1, 3'd0, 7'h01);
        rej("lhs_valid_low",    0, 1, 1, 1, 3'd0, 7'h00);
        rej("rhs_valid_low",    1, 0, 1, 1, 3'd0, 7'h00);
        rej("both_operands_low",0, 0, 1, 1, 3'd0, 7'h00);
        rej("op_valid_low",     1, 1, 0, 1, 3'd0, 7'h00);
        rej("md_valid_low",     1, 1, 1, 0, 3'd0, 7'h00);
        rej("illegal_md7f",     1, 1, 1, 1, 3'd0, 7'h7f);
        rej("illegal_md20_or",  1, 1, 1, 1, 3'd6, 7'h20);
        rej("illegal_md20_sll", 1, 1, 1, 1, 3'd1, 7'h20);

        op_ok("add_0_0",      3'd0, 7'h00, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000);
        op_ok("add_1_0",      3'd0, 7'h00, 32'h0000_0001, 32'h0000_0000, 32'h0000_0001);
        op_ok("add_carry",    3'd0, 7'h00, 32'h0000_0001, 32'h0000_ffff, 32'h0001_0000);
        op_ok("add_wrap",     3'd0, 7'h00, 32'h0000_0001, 32'hffff_ffff, 32'h0000_0000);
        op_ok("sub_0_0",      3'd0, 7'h20, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000);
        op_ok("sub_wrap",     3'd0, 7'h20, 32'h0000_0000, 32'h0000_0001, 32'hffff_ffff);
        op_ok("sub_borrow",   3'd0, 7'h20, 32'h0001_0000, 32'h0000_0001, 32'h0000_ffff);

        op_ok("xor",          3'd4, 7'h00, 32'h1111_ffff, 32'h0204_f0f0, 32'h1315_0f0f);
        op_ok("or",           3'd6, 7'h00, 32'h1020_f171, 32'he0d1_f886, 32'hf0f1_f9f7);
        op_ok("and",          3'd7, 7'h00, 32'h0ff8_12a6, 32'hff17_2583, 32'h0f10_0082);

        op_ok("sll_1",        3'd1, 7'h00, 32'hf2f8_3107, 32'd1,  32'he5f0_620e);
        op_ok("sll_0",        3'd1, 7'h00, 32'hf2f8_3107, 32'd0,  32'hf2f8_3107);
        op_ok("sll_4",        3'd1, 7'h00, 32'hf2f8_3107, 32'd4,  32'h2f83_1070);
        op_ok("sll_32",       3'd1, 7'h00, 32'hf2f8_3107, 32'd32, 32'h0000_0000);
        op_ok("sll_33",       3'd1, 7'h00, 32'hf2f8_3107, 32'd33, 32'h0000_0000);
        op_ok("srl_1",        3'd5, 7'h00, 32'h4863_201f, 32'd1,  32'h2431_900f);
        op_ok("srl_0",        3'd5, 7'h00, 32'h4863_201f, 32'd0,  32'h4863_201f);
        op_ok("srl_4",        3'd5, 7'h00, 32'h4863_201f, 32'd4,  32'h0486_3201);
        op_ok("srl_32",       3'd5, 7'h00, 32'h4863_201f, 32'd32, 32'h0000_0000);
        op_ok("srl_big",      3'd5, 7'h00, 32'h4863_201f, 32'h0000_0101, 32'h0000_0000);
        op_ok("sra_1",        3'd5, 7'h20, 32'ha863_201f, 32'd1,  32'hd431_900f);
        op_ok("sra_0",        3'd5, 7'h20, 32'ha863_201f, 32'd0,  32'ha863_201f);
        op_ok("sra_4",        3'd5, 7'h20, 32'ha863_201f, 32'd4,  32'hfa86_3201);
        op_ok("sra_32",       3'd5, 7'h20, 32'ha863_201f, 32'd32, 32'hffff_ffff);
        op_ok("sra_32_pos",   3'd5, 7'h20, 32'h4863_201f, 32'd32, 32'h0000_0000);
        op_ok("sra_max_neg",  3'd5, 7'h20, 32'h8000_0000, 32'hffff_ffff, 32'hffff_ffff);

        op_ok("slt_0_m1",     3'd2, 7'h00, 32'h0000_0000, 32'hffff_ffff, 32'h0000_0000);
        op_ok("slt_m1_0",     3'd2, 7'h00, 32'hffff_ffff, 32'h0000_0000, 32'h0000_0001);
        op_ok("slt_0_0",      3'd2, 7'h00, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000);
        op_ok("sltu_0_max",   3'd3, 7'h00, 32'h0000_0000, 32'hffff_ffff, 32'h0000_0001);
        op_ok("sltu_max_0",   3'd3, 7'h00, 32'hffff_ffff, 32'h0000_0000, 32'h0000_0000);
        op_ok("sltu_0_0",     3'd3, 7'h00, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000);

        // Mid-stream reset: A is visible, B is dropped before it is captured.
        op_ok("add_before_rst", 3'd0, 7'h00, 32'h0000_0010, 32'h0000_0020, 32'h0000_0030);
        set_inputs(1'b1, 1'b1, 1'b1, 1'b1, 3'd0, 7'h00, 32'h0000_0100, 32'h0000_0200);
        #2;
        rst = 1'b0;
        #1;
        check_now("async_reset_clear", 1'b0, 32'h0);
        @(posedge clk);
        #1;
        check_now("reset_held", 1'b0, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        op_ok("add_after_rst", 3'd0, 7'h00, 32'h0000_1000, 32'h0000_0234, 32'h0000_1234);
        op_ok("and_after_rst", 3'd7, 7'h00, 32'hffff_0000, 32'h0f0f_0f0f, 32'h0f0f_0000);
        rej("idle_after_rst",  0, 0, 0, 0, 3'd0, 7'h00);

        set_inputs(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 7'h00, 32'h0, 32'h0);
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain: got %0d pending, expected 0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
